// File: rtl/dma_wr_output_tile.sv
// Write-back DMA: drains one TOX x TOY x TOF output tile from the on-chip buffer
// and streams it to external memory as row bursts on a valid/ready write channel.
module dma_wr_output_tile #(
    parameter int TOX    = 14,
    parameter int TOY    = 14,
    parameter int TOF    = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int BUF_AW = $clog2(TOX*TOY*TOF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [ADDR_W-1:0] fmap_stride,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    output logic [BUF_AW-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_last
);

    localparam int TOTAL = TOX * TOY * TOF;
    localparam int XW    = $clog2(TOX + 1);
    localparam int YW    = $clog2(TOY + 1);
    localparam int FW    = $clog2(TOF + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] row_stride_q;
    logic [ADDR_W-1:0] fmap_stride_q;
    logic [BUF_AW-1:0] rd_addr;
    logic              rd_pending;

    logic [DATA_W-1:0] fifo_mem [0:1];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_count;

    logic [XW-1:0]     wx;
    logic [YW-1:0]     wy;
    logic [FW-1:0]     wf;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] fmap_base;

    logic start_ok;
    logic rd_last;
    logic beat_fire;
    logic bypass;
    logic push;
    logic pop;
    logic wr_last_x;
    logic wr_last_y;
    logic wr_final;

    assign start_ok  = (state == S_IDLE) && start;
    assign rd_last   = (rd_addr == BUF_AW'(TOTAL - 1));
    assign wr_last_x = (wx == XW'(TOX - 1));
    assign wr_last_y = (wy == YW'(TOY - 1));
    assign wr_final  = wr_last_x && wr_last_y && (wf == FW'(TOF - 1));

    // A new read may issue only while the buffered plus in-flight words stay below the FIFO depth.
    assign buf_rd_en   = (state == S_RUN) && ((fifo_count + 2'(rd_pending)) < 2'd2);
    assign buf_rd_addr = rd_addr;

    // Incoming read data goes straight to the write port when the FIFO is empty.
    assign mem_wr_valid = (fifo_count != 2'd0) || rd_pending;
    assign beat_fire    = mem_wr_valid && mem_wr_ready;
    assign bypass       = beat_fire && (fifo_count == 2'd0);
    assign push         = rd_pending && !bypass;
    assign pop          = beat_fire && (fifo_count != 2'd0);

    always_comb begin
        // NOTE: default first so every path assigns mem_wr_data and no latch is inferred.
        mem_wr_data = '0;
        if (fifo_count != 2'd0)
            mem_wr_data = fifo_mem[fifo_rd_ptr];
        else if (rd_pending)
            mem_wr_data = buf_rd_data;
    end

    assign mem_wr_addr = row_base + ADDR_W'(wx);
    assign mem_wr_last = mem_wr_valid && wr_last_x;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            row_stride_q  <= '0;
            fmap_stride_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state         <= S_RUN;
                    row_stride_q  <= row_stride;
                    fmap_stride_q <= fmap_stride;
                end
                S_RUN:   if (buf_rd_en && rd_last) state <= S_FLUSH;
                S_FLUSH: if (beat_fire && wr_final) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer layout is f*TOY*TOX + y*TOX + x, so x-innermost order is a linear count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr    <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= buf_rd_en;
            if (start_ok)
                rd_addr <= '0;
            else if (buf_rd_en && !rd_last)
                rd_addr <= rd_addr + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; fifo_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wr_ptr] <= buf_rd_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
            if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    // Beat address generator: running row/fmap bases accumulate the strides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wx        <= '0;
            wy        <= '0;
            wf        <= '0;
            row_base  <= '0;
            fmap_base <= '0;
        end else if (start_ok) begin
            wx        <= '0;
            wy        <= '0;
            wf        <= '0;
            row_base  <= base_addr;
            fmap_base <= base_addr;
        end else if (beat_fire) begin
            if (wr_last_x) begin
                wx <= '0;
                if (wr_last_y) begin
                    wy        <= '0;
                    wf        <= wf + 1'b1;
                    fmap_base <= fmap_base + fmap_stride_q;
                    row_base  <= fmap_base + fmap_stride_q;
                end else begin
                    wy       <= wy + 1'b1;
                    row_base <= row_base + row_stride_q;
                end
            end else begin
                wx <= wx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_wr_output_tile.sv
// Self-checking bench for dma_wr_output_tile: scoreboard of expected beats,
// spot-check table for the nominal tile, and hand sequences for stall/abort corners.
module tb_dma_wr_output_tile;

    localparam int TOX = 14, TOY = 14, TOF = 8, TOTAL = TOX * TOY * TOF;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [15:0] data;
        logic        last;
    } spot_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0, row_stride = '0, fmap_stride = '0;
    logic        busy, done, buf_rd_en, mem_wr_valid, mem_wr_last;
    logic [10:0] buf_rd_addr;
    logic [15:0] buf_rd_data = '0;
    logic        mem_wr_ready = 1'b0;
    logic [31:0] mem_wr_addr;
    logic [15:0] mem_wr_data;

    dma_wr_output_tile dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .row_stride(row_stride), .fmap_stride(fmap_stride),
        .busy(busy), .done(done),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last)
    );

    always #5 clk = ~clk;

    // Output buffer model preloaded with data = buffer address.
    logic [15:0] buf_mem [0:TOTAL-1];
    initial for (int i = 0; i < TOTAL; i++) buf_mem[i] = 16'(i);
    always @(posedge clk) if (buf_rd_en) buf_rd_data <= buf_mem[buf_rd_addr];

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and monitor state.
    beat_t       sb[$];
    int          beat_cnt = 0, done_cnt = 0, issued = 0, accepted = 0, max_out = 0;
    int          first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
    logic [31:0] cap_addr [0:TOTAL-1];
    logic [15:0] cap_data [0:TOTAL-1];
    logic        cap_last [0:TOTAL-1];
    bit          stall_prev = 0;
    beat_t       held;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (buf_rd_en) issued++;
            if (stall_prev)
                check(mem_wr_valid && mem_wr_addr == held.addr && mem_wr_data == held.data
                      && mem_wr_last == held.last, "stall_hold",
                      {mem_wr_valid, mem_wr_last, mem_wr_data, mem_wr_addr},
                      {1'b1, held.last, held.data, held.addr});
            if (mem_wr_valid && mem_wr_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "extra_beat", {mem_wr_data, mem_wr_addr}, 64'h0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check(mem_wr_addr == e.addr && mem_wr_data == e.data && mem_wr_last == e.last,
                          "beat", {mem_wr_last, mem_wr_data, mem_wr_addr}, {e.last, e.data, e.addr});
                end
                if (beat_cnt < TOTAL) begin
                    cap_addr[beat_cnt] = mem_wr_addr;
                    cap_data[beat_cnt] = mem_wr_data;
                    cap_last[beat_cnt] = mem_wr_last;
                end
                if (beat_cnt == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beat_cnt++;
                accepted++;
            end
            stall_prev = mem_wr_valid && !mem_wr_ready;
            held.addr  = mem_wr_addr;
            held.data  = mem_wr_data;
            held.last  = mem_wr_last;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = random 50%, 2 = held low for 100 valid cycles.
    int ready_mode = 0, hold_left = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: mem_wr_ready = 1'b1;
            1: mem_wr_ready = 1'($urandom_range(0, 1));
            default: begin
                if (hold_left > 0) begin
                    mem_wr_ready = 1'b0;
                    if (mem_wr_valid) hold_left--;
                end else begin
                    mem_wr_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic start_tile(input logic [31:0] b, input logic [31:0] rs, input logic [31:0] fs);
        sb.delete();
        for (int f = 0; f < TOF; f++)
            for (int y = 0; y < TOY; y++)
                for (int x = 0; x < TOX; x++) begin
                    beat_t e;
                    e.addr = b + 32'(f) * fs + 32'(y) * rs + 32'(x);
                    e.data = 16'(f * TOY * TOX + y * TOX + x);
                    e.last = (x == TOX - 1);
                    sb.push_back(e);
                end
        beat_cnt = 0; done_cnt = 0; issued = 0; accepted = 0; max_out = 0;
        base_addr = b; row_stride = rs; fmap_stride = fs;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int k = 0;
        while (beat_cnt < n && k < 10000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(beat_cnt >= n, name, 64'(beat_cnt), 64'(n));
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done_cnt == 0 && k < 10000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(done_cnt != 0, name, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_tile_end(input string name);
        repeat (3) @(posedge clk);
        #1;
        check(beat_cnt == TOTAL, {name, "_beats"}, 64'(beat_cnt), 64'(TOTAL));
        check(sb.size() == 0, {name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check(done_cnt == 1, {name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check(max_out <= 2, {name, "_outstanding"}, 64'(max_out), 64'd2);
        check(!busy && !mem_wr_valid, {name, "_idle"}, {busy, mem_wr_valid}, 64'd0);
    endtask

    function automatic logic [63:0] out_vec();
        return {busy, done, buf_rd_en, mem_wr_valid, mem_wr_last, mem_wr_data, mem_wr_addr};
    endfunction

    spot_t spots [6];

    initial begin
        spots[0] = '{0,    32'h0000_1000, 16'd0,    1'b0};
        spots[1] = '{13,   32'h0000_100D, 16'd13,   1'b1};
        spots[2] = '{14,   32'h0000_1038, 16'd14,   1'b0};
        spots[3] = '{15,   32'h0000_1039, 16'd15,   1'b0};
        spots[4] = '{196,  32'h0000_1C40, 16'd196,  1'b0};
        spots[5] = '{1567, 32'h0000_68A5, 16'd1567, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check(out_vec() == 64'd0, "reset_outputs", out_vec(), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: nominal tile, ready held high.
        ready_mode = 0;
        start_tile(32'h1000, 32'd56, 32'd3136);
        check(busy && !mem_wr_valid, "t1_busy_no_valid", {busy, mem_wr_valid}, 64'b10);
        @(posedge clk);
        #1;
        check(mem_wr_valid, "t1_first_valid", 64'(mem_wr_valid), 64'd1);
        wait_done("t1_done_timeout");
        check(done_cyc == last_beat_cyc + 1, "t1_done_timing", 64'(done_cyc - last_beat_cyc), 64'd1);
        check(last_beat_cyc - first_beat_cyc == TOTAL - 1, "t1_throughput",
              64'(last_beat_cyc - first_beat_cyc), 64'(TOTAL - 1));
        for (int i = 0; i < 6; i++)
            check(cap_addr[spots[i].idx] == spots[i].addr && cap_data[spots[i].idx] == spots[i].data
                  && cap_last[spots[i].idx] == spots[i].last, $sformatf("t1_spot_%0d", spots[i].idx),
                  {cap_last[spots[i].idx], cap_data[spots[i].idx], cap_addr[spots[i].idx]},
                  {spots[i].last, spots[i].data, spots[i].addr});
        check_tile_end("t1");

        // 2: random backpressure.
        ready_mode = 1;
        start_tile(32'h1000, 32'd56, 32'd3136);
        wait_done("t2_done_timeout");
        check_tile_end("t2");

        // 3: long stall on the first beat.
        ready_mode = 2;
        hold_left = 100;
        start_tile(32'h4000, 32'd56, 32'd3136);
        repeat (60) @(posedge clk);
        #1;
        check(mem_wr_valid && mem_wr_addr == 32'h4000 && mem_wr_data == 16'd0, "t3_beat0_held",
              {mem_wr_valid, mem_wr_data, mem_wr_addr}, {1'b1, 16'd0, 32'h4000});
        check(beat_cnt == 0, "t3_no_beats_stalled", 64'(beat_cnt), 64'd0);
        wait_done("t3_done_timeout");
        check_tile_end("t3");

        // 4: start mid-transfer is ignored.
        ready_mode = 1;
        start_tile(32'h1000, 32'd56, 32'd3136);
        wait_beats(500, "t4_reach_500");
        base_addr = 32'h9000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4_done_timeout");
        repeat (20) @(posedge clk);
        check_tile_end("t4");

        // 5: reset mid-transfer aborts, then a fresh tile.
        ready_mode = 0;
        start_tile(32'h1000, 32'd56, 32'd3136);
        wait_beats(700, "t5_reach_700");
        #2;
        reset = 1'b1;
        #1;
        check(out_vec() == 64'd0, "t5_reset_outputs", out_vec(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check(done_cnt == 0 && !busy, "t5_no_done_abort", {busy, 32'(done_cnt)}, 64'd0);
        start_tile(32'h2000, 32'd56, 32'd3136);
        wait_done("t5_done_timeout");
        check(cap_addr[0] == 32'h2000 && cap_data[0] == 16'd0, "t5_restart_beat0",
              {cap_data[0], cap_addr[0]}, {16'd0, 32'h2000});
        check_tile_end("t5");

        // 6: address wrap through zero.
        ready_mode = 1;
        start_tile(32'hFFFF_FFF0, 32'd14, 32'd196);
        wait_done("t6_done_timeout");
        check(cap_addr[16] == 32'h0000_0000 && cap_addr[TOTAL-1] == 32'h0000_060F, "t6_wrap",
              {cap_addr[16], cap_addr[TOTAL-1]}, {32'h0, 32'h0000_060F});
        check_tile_end("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
